// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with preset load, start/pause, prescaled tick and terminal detect.
// Optional COUNTDOWN_AUTORELOAD_EN: reload the last preset after one full period at zero.
module bcd_countdown #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned DIV    = 100000000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   preset_i,
   input  logic                  start_i,
   input  logic                  pause_i,
   output logic [4*DIGITS-1:0]   cnt,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int unsigned W = 4 * DIGITS;
   localparam logic [31:0] DivLast = 32'(DIV - 1);

   typedef enum logic [1:0] {Idle, Run, Pause, Done} state_t;

   state_t        state;
   logic [31:0]   presc;
`ifdef COUNTDOWN_AUTORELOAD_EN
   logic [W-1:0]  shadow;
`endif

   function automatic logic preset_ok(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // Borrow ripples through every digit in a single cycle.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] res;
      logic         borrow;
      res    = v;
      borrow = 1'b1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (borrow) begin
            if (v[4*d +: 4] == 4'd0) begin
               res[4*d +: 4] = 4'd9;
            end else begin
               res[4*d +: 4] = v[4*d +: 4] - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
      return res;
   endfunction

   logic          tick;
   logic          preset_valid;
   logic [W-1:0]  cnt_dec;

   assign tick         = (presc == DivLast);
   assign preset_valid = preset_ok(preset_i);
   assign cnt_dec      = bcd_dec(cnt);
   assign busy_o       = (state == Run);

   always_ff @(posedge clk_i) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (rst_i) begin
         state  <= Idle;
         cnt    <= '0;
         presc  <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
         shadow <= '0;
`endif
      end else if (load_i && state != Run) begin
         if (preset_valid) begin
            cnt    <= preset_i;
`ifdef COUNTDOWN_AUTORELOAD_EN
            shadow <= preset_i;
`endif
            presc  <= '0;
            state  <= Idle;
         end else begin
            err_o <= 1'b1;
         end
      end else begin
         unique case (state)
            Idle: begin
               if (start_i && cnt != '0) begin
                  state <= Run;
                  presc <= '0;
               end
            end
            Pause: begin
               if (start_i) state <= Run;
            end
            Run: begin
               if (pause_i) begin
                  state <= Pause;
               end else if (tick) begin
                  presc <= '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
                  // Zero is held for one full period before the preset comes back.
                  if (cnt == '0) begin
                     cnt <= shadow;
                  end else begin
                     cnt <= cnt_dec;
                     if (cnt_dec == '0) begin
                        done_o <= 1'b1;
                        if (shadow == '0) state <= Done;
                     end
                  end
`else
                  cnt <= cnt_dec;
                  if (cnt_dec == '0) begin
                     done_o <= 1'b1;
                     state  <= Done;
                  end
`endif
               end else begin
                  presc <= presc + 32'd1;
               end
            end
            Done: begin
               state <= Done;
            end
            default: begin
               state <= Idle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_countdown.sv
// Scoreboard bench for bcd_countdown: integer-valued reference model, per-cycle expected queue.
`timescale 1ns/1ps
module tb_bcd_countdown;

   localparam int unsigned D    = 3;
   localparam int unsigned DV   = 4;
   localparam int unsigned W    = 4 * D;
   localparam int          MaxV = 10**D - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic [W-1:0]  preset = '0;
   logic [W-1:0]  cnt;
   logic          busy, done, err;

   always #5 clk = ~clk;

   bcd_countdown #(.DIGITS(D), .DIV(DV)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (load),
      .preset_i (preset),
      .start_i  (start),
      .pause_i  (pause),
      .cnt      (cnt),
      .busy_o   (busy),
      .done_o   (done),
      .err_o    (err)
   );

   typedef struct {
      logic [W-1:0] cnt;
      logic         busy;
      logic         done;
      logic         err;
   } exp_t;

   typedef enum {MIdle, MRun, MPause, MDone} mstate_t;

   exp_t    sb[$];
   int      total = 0;
   int      bad = 0;
   int      m_val = 0;
   int      m_shadow = 0;
   int      m_ph = 0;
   mstate_t m_st = MIdle;
   bit      m_done = 0;
   bit      m_err = 0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      t = v;
      r = '0;
      for (int i = 0; i < int'(D); i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int from_bcd(input logic [W-1:0] b);
      int v;
      int scale;
      v = 0;
      scale = 1;
      for (int i = 0; i < int'(D); i++) begin
         v = v + int'(b[4*i +: 4]) * scale;
         scale = scale * 10;
      end
      return v;
   endfunction

   function automatic bit digits_ok(input logic [W-1:0] b);
      for (int i = 0; i < int'(D); i++) begin
         if (b[4*i +: 4] > 4'd9) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step(input bit r, input bit l, input logic [W-1:0] p,
                             input bit s, input bit pa);
      m_done = 0;
      m_err  = 0;
      if (r) begin
         m_val = 0; m_shadow = 0; m_ph = 0; m_st = MIdle;
      end else if (l && m_st != MRun) begin
         if (digits_ok(p)) begin
            m_val = from_bcd(p); m_shadow = m_val; m_ph = 0; m_st = MIdle;
         end else begin
            m_err = 1;
         end
      end else begin
         case (m_st)
            MIdle:  if (s && m_val != 0) begin m_st = MRun; m_ph = 0; end
            MPause: if (s) m_st = MRun;
            MRun: begin
               if (pa) begin
                  m_st = MPause;
               end else if (m_ph == int'(DV) - 1) begin
                  m_ph = 0;
                  if (m_val == 0) begin
                     m_val = m_shadow;
                  end else begin
                     m_val = m_val - 1;
                     if (m_val == 0) begin
                        m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (m_shadow == 0) m_st = MDone;
`else
                        m_st = MDone;
`endif
                     end
                  end
               end else begin
                  m_ph = m_ph + 1;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input bit r, input bit l, input int p, input bit s, input bit pa);
      exp_t e;
      logic [W-1:0] pv;
      pv = W'(p);
      @(negedge clk);
      rst = r; load = l; preset = pv; start = s; pause = pa;
      model_step(r, l, pv, s, pa);
      e.cnt  = to_bcd(m_val);
      e.busy = (m_st == MRun);
      e.done = m_done;
      e.err  = m_err;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are sampled just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cnt",  32'(cnt),  32'(e.cnt));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("err",  32'(err),  32'(e.err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      int v;
      int p;
      logic [W-1:0] pb;
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);                 // start with cnt==0 is ignored
      cyc(0, 1, 'h012, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(14);
      cyc(0, 1, 'h055, 0, 0);             // load in RUN ignored
      cyc(0, 0, 0, 1, 1);                 // pause wins in RUN
      idle(3);
      cyc(0, 0, 0, 1, 1);                 // start wins in PAUSE
      idle(45);
      cyc(0, 0, 0, 1, 0);                 // start in DONE ignored
      idle(3);
      cyc(0, 1, 'h100, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(4);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 'h1A0, 0, 0);             // invalid digit rejected
      idle(2);
      cyc(0, 1, 'h005, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(1);
      cyc(0, 0, 0, 0, 1);
      idle(10);
      cyc(0, 0, 0, 1, 0);
      idle(4);
      cyc(0, 1, 'h020, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(6);
      cyc(1, 0, 0, 0, 0);                 // reset mid-count
      idle(2);
      cyc(0, 1, 'h003, 0, 0);
      cyc(0, 0, 0, 1, 0);
      idle(30);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) v = $urandom_range(0, MaxV);
         else v = $urandom_range(0, 12);
         pb = to_bcd(v);
         if ($urandom_range(0, 3) == 0)
            pb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         p = int'(pb);
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), p,
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      end
      idle(1);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
